// File: rtl/memory_responder.sv
// Wait-state memory responder: latches one read or write request, waits
// WAIT_CYCLES edges, performs the access and acknowledges it with a four-phase handshake.
module memory_responder #(
   parameter int unsigned BITS        = 32,
   parameter int unsigned ADDR_BITS   = 9,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Read,
   input  logic            Write,
   input  logic [BITS-1:0] MARVal,
   input  logic [BITS-1:0] MDRVal,
   output logic [BITS-1:0] MDataIn,
   output logic            Done,
   output logic            Busy,
   output logic            Err
);

   localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
   localparam int unsigned CNT_BITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [CNT_BITS-1:0]   cnt;
   logic [CNT_BITS-1:0]   cnt_next;
   logic                  op_write;
   logic                  op_write_next;
   logic [ADDR_BITS-1:0]  addr;
   logic [ADDR_BITS-1:0]  addr_next;
   logic [BITS-1:0]       wdata;
   logic [BITS-1:0]       wdata_next;
   logic                  done_next;
   logic                  busy_next;
   logic                  err_next;
   logic                  commit;
   logic                  load_rd;

   logic [BITS-1:0]       mem [DEPTH];

   // Address bits above ADDR_BITS alias by design.
   logic                  unused_mar;
   assign unused_mar = ^MARVal[BITS-1:ADDR_BITS];

   // Next-state, latch and registered-output decode
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      op_write_next = op_write;
      addr_next     = addr;
      wdata_next    = wdata;
      err_next      = 1'b0;
      commit        = 1'b0;
      load_rd       = 1'b0;

      case (state)
         ST_IDLE: begin
            if (Read ^ Write) begin
               op_write_next = Write;
               addr_next     = MARVal[ADDR_BITS-1:0];
               wdata_next    = MDRVal;
               cnt_next      = CNT_BITS'(WAIT_CYCLES);
               state_next    = ST_WAIT;
            end else if (Read && Write) begin
               err_next = 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt != '0) begin
               cnt_next = cnt - 1'b1;
            end else begin
               state_next = ST_DONE;
               commit     = op_write;
               load_rd    = !op_write;
            end
         end
         ST_DONE: begin
            if (!Read && !Write) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      busy_next = (state_next == ST_WAIT);
      done_next = (state_next == ST_DONE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_write <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
         Done     <= 1'b0;
         Busy     <= 1'b0;
         Err      <= 1'b0;
         MDataIn  <= '0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         op_write <= op_write_next;
         addr     <= addr_next;
         wdata    <= wdata_next;
         Done     <= done_next;
         Busy     <= busy_next;
         Err      <= err_next;
         if (load_rd) begin
            MDataIn <= mem[addr];
         end
      end
   end

   // Storage array survives reset; an aborted write never commits.
   always_ff @(posedge clk) begin
      if (!reset && commit) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
// Randomized self-checking bench for memory_responder against a word-array
// model, plus a second zero-wait-state instance.
module tb_memory_responder;

   localparam int unsigned WC    = 2;
   localparam int unsigned DEPTH = 512;

   logic        clk = 1'b0;
   logic        reset;
   logic        Read, Write;
   logic [31:0] MARVal, MDRVal;
   logic [31:0] MDataIn;
   logic        Done, Busy, Err;

   logic        z_read, z_write;
   logic [31:0] z_mar, z_mdr;
   logic [31:0] z_mdatain;
   logic        z_done, z_busy, z_err;

   int          checks = 0;
   int          errors = 0;

   logic [31:0] ref_mem   [DEPTH];
   bit          ref_valid [DEPTH];
   logic [31:0] exp_rd;
   logic [31:0] pool      [8];

   always #5 clk = ~clk;

   memory_responder #(.BITS(32), .ADDR_BITS(9), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .reset(reset), .Read(Read), .Write(Write),
      .MARVal(MARVal), .MDRVal(MDRVal), .MDataIn(MDataIn),
      .Done(Done), .Busy(Busy), .Err(Err)
   );

   memory_responder #(.BITS(32), .ADDR_BITS(9), .WAIT_CYCLES(0)) dut_z (
      .clk(clk), .reset(reset), .Read(z_read), .Write(z_write),
      .MARVal(z_mar), .MDRVal(z_mdr), .MDataIn(z_mdatain),
      .Done(z_done), .Busy(z_busy), .Err(z_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Full handshake on the main instance; strobes held for `hold` extra cycles after Done.
   task automatic access(input bit wr, input logic [31:0] mar, input logic [31:0] data,
                         input int hold);
      int          lat;
      int unsigned idx;
      idx = int'(mar % DEPTH);
      @(negedge clk);
      Read = !wr; Write = wr; MARVal = mar; MDRVal = data;
      lat = 0;
      while (!Done && lat < 20) begin
         @(negedge clk);
         lat++;
         MARVal = $urandom;
         MDRVal = $urandom;
         if (!Done) check("busy_wait", 32'(Busy), 32'd1);
      end
      check("latency", 32'(lat - 1), 32'(WC + 1));
      check("busy_at_done", 32'(Busy), 32'd0);
      if (wr) begin
         ref_mem[idx]   = data;
         ref_valid[idx] = 1'b1;
         check("rd_hold_wr", MDataIn, exp_rd);
      end else begin
         exp_rd = ref_mem[idx];
         check("rdata", MDataIn, exp_rd);
      end
      repeat (hold) begin
         @(negedge clk);
         MARVal = $urandom;
         MDRVal = $urandom;
         check("done_hold", 32'(Done), 32'd1);
         check("busy_hold", 32'(Busy), 32'd0);
         check("rdata_hold", MDataIn, exp_rd);
      end
      Read = 1'b0; Write = 1'b0;
      @(negedge clk);
      check("done_clear", 32'(Done), 32'd0);
      check("busy_idle", 32'(Busy), 32'd0);
   endtask

   // Both strobes high in IDLE must pulse Err and touch nothing.
   task automatic illegal(input logic [31:0] mar);
      @(negedge clk);
      Read = 1'b1; Write = 1'b1; MARVal = mar; MDRVal = $urandom;
      @(negedge clk);
      check("err_pulse", 32'(Err), 32'd1);
      check("err_busy", 32'(Busy), 32'd0);
      check("err_done", 32'(Done), 32'd0);
      check("err_rdata", MDataIn, exp_rd);
      Read = 1'b0; Write = 1'b0;
      @(negedge clk);
      check("err_clear", 32'(Err), 32'd0);
   endtask

   initial begin
      Read = 0; Write = 0; MARVal = 0; MDRVal = 0;
      z_read = 0; z_write = 0; z_mar = 0; z_mdr = 0;
      exp_rd = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         ref_mem[i] = '0; ref_valid[i] = 1'b0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_err", 32'(Err), 32'd0);
      check("rst_rdata", MDataIn, 32'd0);
      reset = 1'b0;

      // Write then read back, holding the read strobe 5 cycles after Done
      access(1'b1, 32'h005, 32'hDEADBEEF, 0);
      access(1'b0, 32'h005, 32'h0, 5);

      // Illegal request leaves memory and read data alone
      illegal(32'h005);
      access(1'b0, 32'h005, 32'h0, 0);

      // Reset during a write's wait states aborts the commit
      access(1'b1, 32'h010, 32'h0, 0);
      @(negedge clk);
      Write = 1'b1; MARVal = 32'h010; MDRVal = 32'h12345678;
      @(negedge clk);
      check("abort_busy", 32'(Busy), 32'd1);
      reset = 1'b1; Write = 1'b0;
      @(negedge clk);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_busy0", 32'(Busy), 32'd0);
      check("abort_err", 32'(Err), 32'd0);
      check("abort_rdata", MDataIn, 32'd0);
      exp_rd = 32'd0;
      reset = 1'b0;
      access(1'b0, 32'h010, 32'h0, 0);

      // Upper address bits alias
      access(1'b1, 32'h0000_0203, 32'hA5A5A5A5, 0);
      access(1'b0, 32'h0000_0003, 32'h0, 1);

      // Randomized traffic over a small address pool with random upper bits
      for (int i = 0; i < 8; i++) pool[i] = 32'($urandom_range(0, DEPTH - 1));
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         int unsigned k;
         k = $urandom_range(0, 7);
         a = {23'($urandom), pool[k][8:0]};
         if (!ref_valid[pool[k]] || $urandom_range(0, 1) == 0)
            access(1'b1, a, $urandom, int'($urandom_range(0, 3)));
         else if ($urandom_range(0, 7) == 0)
            illegal(a);
         else
            access(1'b0, a, $urandom, int'($urandom_range(0, 3)));
      end

      // Zero-wait-state instance: one edge from accept to Done
      @(negedge clk);
      z_write = 1'b1; z_mar = 32'h007; z_mdr = 32'hCAFEF00D;
      @(negedge clk);
      check("z_wr_busy", 32'(z_busy), 32'd1);
      check("z_wr_done0", 32'(z_done), 32'd0);
      @(negedge clk);
      check("z_wr_done", 32'(z_done), 32'd1);
      check("z_wr_busy0", 32'(z_busy), 32'd0);
      z_write = 1'b0;
      @(negedge clk);
      check("z_wr_clear", 32'(z_done), 32'd0);
      z_read = 1'b1; z_mar = 32'h007;
      @(negedge clk);
      check("z_rd_busy", 32'(z_busy), 32'd1);
      @(negedge clk);
      check("z_rd_done", 32'(z_done), 32'd1);
      check("z_rd_busy0", 32'(z_busy), 32'd0);
      check("z_rdata", z_mdatain, 32'hCAFEF00D);
      check("z_err", 32'(z_err), 32'd0);
      z_read = 1'b0;
      @(negedge clk);
      check("z_rd_clear", 32'(z_done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
